// File: rtl/pixel_ramp_adc_readout.sv
// Single-slope column ADC: ramps dac_code during convert, latches per-column codes
// on comparator trip, then streams them per row. Optional build macro: GRAY_COUNTER_EN.
module pixel_ramp_adc_readout #(
    parameter int N_COL = 4,
    parameter int W     = 8,
    parameter int COL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             convert,
    input  logic [3:0]       read,
    input  logic [N_COL-1:0] cmp,
    output logic [W-1:0]     dac_code,
    output logic [W-1:0]     out_data,
    output logic [COL_W-1:0] out_col,
    output logic [1:0]       out_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD, STREAM} state_t;

    state_t             state_q, state_d;
    logic               conv_q, conv_prev_q;
    logic [3:0]         read_q, read_prev_q;
    logic [W-1:0]       dac_q, dac_d;
    logic [W-1:0]       latch_q [N_COL];
    logic [W-1:0]       latch_d [N_COL];
    logic [N_COL-1:0]   tripped_q, tripped_d;
    logic [COL_W-1:0]   ptr_q, ptr_d;
    logic [1:0]         row_q, row_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               capture;
    logic               conv_rise, conv_fall, read_start;
    logic [W-1:0]       sel;

`ifdef GRAY_COUNTER_EN
    function automatic logic [W-1:0] enc(input logic [W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [W-1:0] dec(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int unsigned i = 1; i < W; i++) begin
            b[W-1-i] = b[W-i] ^ g[W-1-i];
        end
        return b;
    endfunction
`else
    function automatic logic [W-1:0] enc(input logic [W-1:0] v);
        return v;
    endfunction

    function automatic logic [W-1:0] dec(input logic [W-1:0] g);
        return g;
    endfunction
`endif

    assign conv_rise  = conv_q & ~conv_prev_q;
    assign conv_fall  = ~conv_q & conv_prev_q;
    assign read_start = (read_q != 4'd0) && (read_prev_q == 4'd0);

    always_comb begin
        state_d   = state_q;
        dac_d     = dac_q;
        latch_d   = latch_q;
        tripped_d = tripped_q;
        ptr_d     = ptr_q;
        row_d     = row_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (conv_rise) begin
                    state_d   = CONVERT;
                    tripped_d = '0;
                    capture   = 1'b1;
                    dac_d     = W'(1);
                end
            end
            CONVERT: begin
                if (conv_fall) begin
                    state_d = HOLD;
                    dac_d   = '0;
                    for (int unsigned c = 0; c < N_COL; c++) begin
                        if (!tripped_q[c]) latch_d[c] = enc('1);
                    end
                end else begin
                    capture = 1'b1;
                    if (dac_q != '1) dac_d = dac_q + W'(1);
                end
            end
            HOLD: begin
                if (read_start) begin
                    state_d = STREAM;
                    valid_d = 1'b1;
                    ptr_d   = '0;
                    // Descending scan so the lowest set bit wins.
                    for (int unsigned i = 4; i > 0; i--) begin
                        if (read_q[i-1]) row_d = 2'(i-1);
                    end
                end
            end
            STREAM: begin
                if (valid_q && out_ready) begin
                    if (ptr_q == COL_W'(N_COL-1)) begin
                        valid_d = 1'b0;
                        ptr_d   = '0;
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + COL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture uses the code shown this cycle; edge cycle shows 0.
        if (capture) begin
            for (int unsigned c = 0; c < N_COL; c++) begin
                if (cmp[c] && !tripped_d[c]) begin
                    latch_d[c]   = enc(dac_q);
                    tripped_d[c] = 1'b1;
                end
            end
        end

        if (conv_rise && (state_q == HOLD || state_q == STREAM)) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            conv_q      <= 1'b0;
            conv_prev_q <= 1'b0;
            read_q      <= '0;
            read_prev_q <= '0;
            dac_q       <= '0;
            latch_q     <= '{default: '0};
            tripped_q   <= '0;
            ptr_q       <= '0;
            row_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_q      <= convert;
            conv_prev_q <= conv_q;
            read_q      <= read;
            read_prev_q <= read_q;
            dac_q       <= dac_d;
            latch_q     <= latch_d;
            tripped_q   <= tripped_d;
            ptr_q       <= ptr_d;
            row_q       <= row_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        sel = '0;
        for (int unsigned c = 0; c < N_COL; c++) begin
            if (ptr_q == COL_W'(c)) sel = latch_q[c];
        end
    end

    assign dac_code  = dac_q;
    assign out_data  = dec(sel);
    assign out_col   = ptr_q;
    assign out_row   = row_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: doc/pixel_ramp_adc_readout.md
Name: pixel_ramp_adc_readout

Overview:
- Downstream stage of the pixel state FSM. It consumes that FSM's convert and read[3:0] phase outputs.
- During convert it runs a single-slope ramp counter that drives the ramp DAC. It latches one code per column when that column's comparator trips.
- On a read strobe it streams the latched column codes, tagged with row index, over a valid/ready handshake to the data path.

Parameters:
- N_COL, 4, number of columns / comparator inputs (2..16).
- W, 8, ramp counter and sample width; full scale 2^W-1 (255 for the 255-cycle convert window).
- COL_W, 4, width of out_col; must satisfy 2^COL_W >= N_COL.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- convert  in  1  convert phase from pixel state FSM.
- read  in  4  read phase strobes from pixel state FSM; bit i = row i.
- cmp  in  N_COL  comparator outputs; 1 = ramp has crossed the pixel level.
- dac_code  out  W  ramp DAC code.
- out_data  out  W  column sample.
- out_col  out  COL_W  column index of out_data.
- out_row  out  2  row index of the current burst.
- out_valid  out  1  sample valid.
- out_ready  in  1  downstream accepts the sample.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; dac_code=0; all column latches=0; tripped mask=0; out_data=0; out_col=0; out_row=0; out_valid=0; busy=0; overrun=0.
- convert and read are sampled registered. Edge detection uses the previous-cycle sampled values. Reset clears these history registers.
- States: IDLE, CONVERT, HOLD, STREAM.
- IDLE -> CONVERT on convert rising edge.
  - Cycle of the edge: dac_code=0, tripped mask cleared.
  - dac_code then increments by 1 each cycle while convert=1.
  - dac_code saturates at 2^W-1 and never wraps.
- CONVERT, per column c: on the first cycle cmp[c]=1 with tripped[c]=0, latch[c]<=dac_code and tripped[c]<=1.
  - Later cmp toggles on that column are ignored.
  - cmp[c] already 1 on the convert edge cycle latches 0.
- CONVERT -> HOLD on convert falling edge.
  - Columns with tripped=0 get latch = 2^W-1 (clip).
  - dac_code returns to 0.
- HOLD -> STREAM on read transition from 0 to nonzero.
  - out_row = index of the lowest set bit of read.
  - Column pointer = 0.
  - read already nonzero on entry to HOLD does not start a burst; a fresh 0-to-nonzero transition is required.
- STREAM:
  - out_valid=1 with out_data=latch[ptr], out_col=ptr.
  - Values are held stable until a cycle with out_valid&out_ready.
  - On handshake ptr increments and the next column appears the following cycle, so back-to-back throughput is 1 sample/cycle.
  - After handshake of column N_COL-1: out_valid=0 next cycle, state -> IDLE.
- Latches persist after a burst. A later read edge in IDLE does not replay; a new convert is required.
- convert rising edge while in HOLD or STREAM: edge ignored (no new conversion), overrun<=1. Current burst continues unaffected.
- read edges in IDLE or CONVERT are ignored.
- overrun clears only on reset.
- Reset mid-burst or mid-conversion aborts immediately to the reset values above.

Optional Feature:
- Macro GRAY_COUNTER_EN.
- Defined: column latches capture the Gray-coded ramp count (dac_code ^ (dac_code>>1)). Clip value is the Gray encoding of 2^W-1. Latched values are Gray-to-binary decoded combinationally at the stream output, so out_data is identical to the non-Gray build. dac_code stays binary.
- Undefined: latches store binary dac_code directly; no decode logic.

Test Plan:
- Conversion: convert high 255 cycles; cmp[0] rises at ramp 10, cmp[1] at 100, cmp[2] at 254, cmp[3] never. Then read=4'b0010 with out_ready=1 -> samples (col0,10),(col1,100),(col2,254),(col3,255), all out_row=1, on 4 consecutive cycles.
- Backpressure: out_ready toggled 1,0,0,1,... -> each column held stable while stalled; no sample dropped or duplicated; exactly 4 handshakes.
- Saturation: convert high 300 cycles, no cmp -> dac_code reaches 255 and holds; all samples 255.
- Overrun: convert edge during STREAM -> overrun=1 and stays 1; burst completes with the original values; dac_code stays 0.
- Read filtering: read=4'b1100 held from before convert falls -> no burst. read back to 0 then 4'b1100 -> burst with out_row=2.
- Async reset: reset=0 mid-STREAM after 2 handshakes -> all outputs 0 immediately. GRAY_COUNTER_EN build repeats the conversion scenario with identical expected values.
